// File: rtl/prime_bcd_converter.sv
// Binary-to-packed-BCD converter for the prime generator output stream.
// Sequential double-dabble, one bit per clock, valid/ready on both sides.
module prime_bcd_converter #(
  parameter int WIDTH  = 21,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_value,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DIGITS*4-1:0]   out_bcd,
  output logic [2:0]            out_ndigits,
  input  logic                  out_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [WIDTH-1:0]      bin_r;
  logic [DIGITS*4-1:0]   bcd_r;
  logic [CW-1:0]         cnt_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [DIGITS*4-1:0]   out_bcd_r;
  logic [2:0]            out_ndigits_r;

  logic [DIGITS*4-1:0]   bcd_adj_s;
  logic [DIGITS*4-1:0]   bcd_shift_s;
  logic [WIDTH-1:0]      bin_shift_s;
  logic [2:0]            ndigits_s;
  logic                  accept_s;

  // Nibble pre-correction: 4-bit add without carry-out, so a digit never exceeds 9 after the shift.
  function automatic logic [3:0] nib_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_bcd     = out_bcd_r;
  assign out_ndigits = out_ndigits_r;
  assign accept_s    = in_valid && in_ready_r;

  // One double-dabble step and the significant-digit count of its result.
  always_comb begin
    bcd_adj_s = '0;
    ndigits_s = 3'd1;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj_s[i*4 +: 4] = nib_adj(bcd_r[i*4 +: 4]);
    end
    bcd_shift_s = {bcd_adj_s[DIGITS*4-2:0], bin_r[WIDTH-1]};
    bin_shift_s = {bin_r[WIDTH-2:0], 1'b0};
    for (int i = 0; i < DIGITS; i++) begin
      ndigits_s = (bcd_shift_s[i*4 +: 4] != 4'd0) ? 3'(i + 1) : ndigits_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CW'(1)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Conversion datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r         <= '0;
      bcd_r         <= '0;
      cnt_r         <= '0;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_bcd_r     <= '0;
      out_ndigits_r <= 3'd0;
    end else begin
      in_ready_r <= (state_next_s == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            bin_r <= in_value;
            bcd_r <= '0;
            cnt_r <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          bin_r <= bin_shift_s;
          bcd_r <= bcd_shift_s;
          cnt_r <= cnt_r - CW'(1);
          // Last iteration: publish the result straight from the final shift.
          if (cnt_r == CW'(1)) begin
            out_bcd_r     <= bcd_shift_s;
            out_ndigits_r <= ndigits_s;
            out_valid_r   <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
